branch_fwd_hazard_unit: RTL
===========================

// Module: branch_fwd_hazard_unit
// PURPOSE
//   Next-generation ID-stage branch operand forwarding and hazard controller. For each of NSRC
//   branch source registers, selects the youngest in-flight producer among NSTAGE pipeline stages,
//   or the register file. Stalls ID when that producer is a load whose data is not yet available.
//   Tracks stall episodes with a small FSM, a watchdog and a performance counter.
// PARAMETERS
//   AW          5   register address width; address 0 is hardwired zero, never forwarded
//   NSRC        2   number of branch source operands (channels)
//   NSTAGE      3   producer stages, index 0 = EX (youngest) ... NSTAGE-1 = WB (oldest)
//   LOAD_RDY    2   lowest stage index at which load data is forwardable (loads in 0..LOAD_RDY-1 stall)
//   MAX_STALL   4   consecutive stall cycles before the watchdog flag fires (>=1)
//   CNT_W       16  width of the stall performance counter
//   SW          $clog2(NSTAGE+1)  select width (derived localparam, not overridable)
// PORTS
//   clk           in   1           rising-edge clock
//   rst           in   1           asynchronous active-high reset
//   br_valid      in   1           a branch is being resolved in ID this cycle
//   flush         in   1           pipeline flush; cancels any stall episode
//   src_addr      in   NSRC*AW     packed source register addresses, channel c at [c*AW +: AW]
//   stg_rw        in   NSTAGE*AW   packed destination register per stage
//   stg_regwr     in   NSTAGE      per-stage register-write enable
//   stg_load      in   NSTAGE      per-stage "result comes from memory" flag
//   fwd_sel       out  NSRC*SW     per channel: 0 = register file, k = forward from stage k-1
//   id_stall      out  1           hold PC/IF/ID, inject bubble into EX
//   stall_timeout out  1           sticky watchdog flag
//   stall_cnt     out  CNT_W       total stall cycles since reset, saturating
// BEHAVIOUR
//   Reset: state=IDLE, run counter=0, stall_timeout=0, stall_cnt=0. While rst=1, fwd_sel=0 and
//     id_stall=0.
//   Match: stage s matches channel c when stg_regwr[s] && stg_rw[s]!=0 && stg_rw[s]==src_addr[c].
//   Select (combinational, same cycle): the lowest matching s wins and fwd_sel[c]=s+1. With no
//     match, fwd_sel[c]=0. Older matches are ignored even if the youngest match is a stalling load.
//   Hazard: channel c is hazardous when its winning stage s has stg_load[s]=1 and s<LOAD_RDY.
//     hazard = OR over channels.
//   id_stall = br_valid && hazard && !flush (combinational). fwd_sel is still driven while stalled.
//   FSM (registered, updates on clk):
//     IDLE  -> STALL when id_stall=1; run counter <= 1.
//     STALL -> STALL while id_stall=1; run counter increments, saturating at MAX_STALL.
//     STALL -> IDLE when id_stall=0 (hazard cleared, br_valid dropped, or flush); run counter <= 0.
//     flush=1 forces IDLE next cycle from either state. It has priority over all other inputs.
//   Watchdog: stall_timeout <= 1 on the edge where run counter would reach MAX_STALL.
//     Stays 1 until rst. It does not suppress id_stall.
//   stall_cnt increments by 1 on every clk edge where id_stall=1, and saturates at 2^CNT_W-1.
//   Async rst mid-episode: all registers clear immediately and combinational outputs drop to 0.
//     After release, the unit re-evaluates from IDLE on the next edge.
//   Non-branch cycles (br_valid=0): fwd_sel is still computed. No stall, no count.
// TESTING
//   1 No match: src_addr={5'd9,5'd8}, all stg_regwr=0 -> fwd_sel={0,0}, id_stall=0.
//   2 Priority: rs=8, EX and MEM both write r8 (ALU) -> fwd_sel[0]=1. Clear EX regwr -> fwd_sel[0]=2.
//   3 Load-use: br_valid=1, rs=8, EX is a load to r8 -> id_stall=1 in cycle 0, state STALL.
//     Advance the load to MEM next cycle -> stall again. Load reaches WB -> fwd_sel[0]=3, id_stall=0.
//     stall_cnt=2.
//   4 Zero reg: rs=0 with EX writing r0 (load) -> fwd_sel[0]=0, id_stall=0.
//   5 Watchdog and flush: hold EX load hazard 4 cycles -> stall_timeout=1 after 4th edge.
//     Assert flush -> id_stall=0, IDLE next edge, stall_timeout stays 1.
//   6 Async rst during STALL between edges -> outputs 0 immediately, stall_cnt=0, stall_timeout=0.
//     Set stall_cnt near max (CNT_W=4) -> saturates at 15.

Source files
------------

// File: rtl/branch_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// branch_fwd_hazard_unit
//
// ID-stage operand forwarding and load-use hazard control for branch
// resolution. Every branch source operand (channel) is compared against the
// destination registers of the in-flight producer stages. The youngest
// producer that writes the register is selected as the forwarding source. If
// no stage writes it, the operand comes from the register file. When the
// selected producer is a load whose data cannot be forwarded yet, ID is
// stalled. Each stall episode is tracked by a two-state FSM with a run-length
// watchdog. A saturating counter accumulates the total number of stall cycles.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   br_valid       a branch is being resolved in ID this cycle
//   flush          pipeline flush; cancels any stall episode
//   src_addr       NSRC packed source register addresses, channel c at [c*AW +: AW]
//   stg_rw         NSTAGE packed destination registers, stage 0 = EX (youngest)
//   stg_regwr      per-stage register-write enable
//   stg_load       per-stage "result comes from memory" flag
//   fwd_sel        per channel, SW bits: 0 = register file, k = stage k-1
//   id_stall       hold PC/IF/ID and inject a bubble into EX
//   stall_timeout  sticky watchdog flag, set when a stall run reaches MAX_STALL
//   stall_cnt      total stall cycles since reset, saturating
// -----------------------------------------------------------------------------
module branch_fwd_hazard_unit #(
    parameter int AW        = 5,
    parameter int NSRC      = 2,
    parameter int NSTAGE    = 3,
    parameter int LOAD_RDY  = 2,
    parameter int MAX_STALL = 4,
    parameter int CNT_W     = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  br_valid,
    input  logic                                  flush,
    input  logic [NSRC*AW-1:0]                    src_addr,
    input  logic [NSTAGE*AW-1:0]                  stg_rw,
    input  logic [NSTAGE-1:0]                     stg_regwr,
    input  logic [NSTAGE-1:0]                     stg_load,
    output logic [NSRC*$clog2(NSTAGE+1)-1:0]      fwd_sel,
    output logic                                  id_stall,
    output logic                                  stall_timeout,
    output logic [CNT_W-1:0]                      stall_cnt
);

    localparam int SW = $clog2(NSTAGE + 1);
    // Run counter must be able to hold MAX_STALL itself.
    localparam int RW = $clog2(MAX_STALL + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    localparam logic [RW-1:0]    RUN_MAX = RW'(MAX_STALL);
    localparam logic [RW-1:0]    RUN_ONE = RW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // -------------------------------------------------------------------------
    // Producer match and youngest-producer selection
    // -------------------------------------------------------------------------
    logic [SW-1:0]         w_sel [NSRC];
    logic [NSRC-1:0]       w_haz_ch;
    logic                  w_hazard;
    logic                  w_id_stall;
    logic [NSRC*SW-1:0]    w_fwd_packed;

    always_comb begin
        for (int c = 0; c < NSRC; c++) begin
            w_sel[c]    = '0;
            w_haz_ch[c] = 1'b0;
            // Scan oldest to youngest so the youngest match overwrites the
            // older ones. Only the winning stage decides the hazard, so an
            // older ready copy never hides a stalling younger load.
            for (int s = NSTAGE - 1; s >= 0; s--) begin
                if (stg_regwr[s] &&
                    (stg_rw[s*AW +: AW] != '0) &&
                    (stg_rw[s*AW +: AW] == src_addr[c*AW +: AW])) begin
                    w_sel[c]    = SW'(s + 1);
                    w_haz_ch[c] = stg_load[s] && (s < LOAD_RDY);
                end
            end
        end
    end

    always_comb begin
        w_fwd_packed = '0;
        for (int c = 0; c < NSRC; c++) begin
            w_fwd_packed[c*SW +: SW] = w_sel[c];
        end
    end

    assign w_hazard = |w_haz_ch;

    // Outputs are forced low while reset is held so that an asynchronous
    // reset mid-episode releases the pipeline immediately.
    assign w_id_stall = !rst && br_valid && w_hazard && !flush;
    assign id_stall   = w_id_stall;
    assign fwd_sel    = rst ? '0 : w_fwd_packed;

    // -------------------------------------------------------------------------
    // Stall-episode FSM and watchdog
    // -------------------------------------------------------------------------
    logic [0:0]     r_state;
    logic [RW-1:0]  r_run;
    logic           r_timeout;
    logic [RW-1:0]  w_run_inc;

    assign w_run_inc = (r_run >= RUN_MAX) ? RUN_MAX : (r_run + RUN_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_run     <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_id_stall) begin
                        r_state <= ST_STALL;
                        r_run   <= RUN_ONE;
                        if (RUN_ONE >= RUN_MAX) begin
                            r_timeout <= 1'b1;
                        end
                    end else begin
                        r_run <= '0;
                    end
                end
                ST_STALL: begin
                    // flush already forces w_id_stall low, so it falls into
                    // the return-to-IDLE branch ahead of everything else.
                    if (w_id_stall) begin
                        r_state <= ST_STALL;
                        r_run   <= w_run_inc;
                        if (w_run_inc >= RUN_MAX) begin
                            r_timeout <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_run   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_run   <= '0;
                end
            endcase
        end
    end

    assign stall_timeout = r_timeout;

    // -------------------------------------------------------------------------
    // Saturating stall-cycle performance counter
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_id_stall && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_cnt;

endmodule
